// File: rtl/arbitro_enrutador.sv
// Round-robin arbiter/router: pops one word per cycle from input FIFOs 0..3 and
// pushes it, two cycles later, to output FIFO 4..7 chosen by the word's top two bits.
module arbitro_enrutador #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active,
  input  logic [3:0]            fifo_empty_in,
  input  logic [DATA_WIDTH-1:0] fifo_data_in0,
  input  logic [DATA_WIDTH-1:0] fifo_data_in1,
  input  logic [DATA_WIDTH-1:0] fifo_data_in2,
  input  logic [DATA_WIDTH-1:0] fifo_data_in3,
  input  logic [3:0]            almost_full_out,
  output logic [3:0]            pop_in,
  output logic [3:0]            push_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  idle
);

  // Handshake: an input word transfers when pop_in[i]=1 while fifo_empty_in[i]=0
  // (pop is only ever raised for a non-empty FIFO); an output word transfers on
  // every cycle push_out is non-zero, with no ready back from the output FIFOs other
  // than almost_full_out, which stops new pops but never the two words in flight.

  logic                  stall;
  logic                  grant_valid;
  logic [1:0]            grant_idx;
  logic [1:0]            cand;

  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic                  valid_s1_q, valid_s1_d;
  logic [1:0]            src_s1_q, src_s1_d;
  logic [3:0]            push_q, push_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  idle_q, idle_d;
  logic [DATA_WIDTH-1:0] sel_word;

  assign stall = reset | ~active | (|almost_full_out);

  // Scan offsets 3..0 so the lowest offset from rr_ptr, written last, wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_q;
    cand        = rr_ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = rr_ptr_q + 2'(i);
      if (!fifo_empty_in[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (stall) begin
      grant_valid = 1'b0;
    end
  end

  assign pop_in = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    sel_word = fifo_data_in0;
    case (src_s1_q)
      2'd0: sel_word = fifo_data_in0;
      2'd1: sel_word = fifo_data_in1;
      2'd2: sel_word = fifo_data_in2;
      2'd3: sel_word = fifo_data_in3;
      default: sel_word = fifo_data_in0;
    endcase
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    valid_s1_d = grant_valid;
    src_s1_d   = grant_idx;
    push_d     = 4'b0000;
    data_d     = data_q;
    if (grant_valid) begin
      rr_ptr_d = grant_idx + 2'd1;
    end
    // Destination comes only from the word itself, never from the source FIFO.
    if (valid_s1_q) begin
      push_d = 4'b0001 << sel_word[DATA_WIDTH-1:DATA_WIDTH-2];
      data_d = sel_word;
    end
    idle_d = (&fifo_empty_in) & ~valid_s1_q & ~(|pop_in);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= 2'd0;
      valid_s1_q <= 1'b0;
      src_s1_q   <= 2'd0;
      push_q     <= 4'b0000;
      data_q     <= '0;
      idle_q     <= 1'b1;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      valid_s1_q <= valid_s1_d;
      src_s1_q   <= src_s1_d;
      push_q     <= push_d;
      data_q     <= data_d;
      idle_q     <= idle_d;
    end
  end

  assign push_out = push_q;
  assign data_out = data_q;
  assign idle     = idle_q;

endmodule

// File: tb/tb_arbitro_enrutador.sv
// Bench for arbitro_enrutador: behavioural input FIFOs, a round-robin reference
// model for pop_in, and an expected-word queue checked when pushes are due.
module tb_arbitro_enrutador;

  logic       clk;
  logic       reset;
  logic       active;
  logic [3:0] empty_r;
  logic [9:0] rd0, rd1, rd2, rd3;
  logic [3:0] almost_full;
  logic [3:0] pop_in;
  logic [3:0] push_out;
  logic [9:0] data_out;
  logic       idle;

  arbitro_enrutador #(.DATA_WIDTH(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .fifo_empty_in  (empty_r),
    .fifo_data_in0  (rd0),
    .fifo_data_in1  (rd1),
    .fifo_data_in2  (rd2),
    .fifo_data_in3  (rd3),
    .almost_full_out(almost_full),
    .pop_in         (pop_in),
    .push_out       (push_out),
    .data_out       (data_out),
    .idle           (idle)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // input FIFO contents
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];
  logic [9:0] q3[$];

  // scoreboard and reference state
  logic [9:0] exp_q[$];
  logic [1:0] pipe;
  logic [1:0] m_rr;
  logic       exp_idle;
  logic [9:0] m_data;
  int         n_chk;
  int         n_pass;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [9:0] front(input int i);
    case (i)
      0: return (q0.size() != 0) ? q0[0] : 10'h0;
      1: return (q1.size() != 0) ? q1[0] : 10'h0;
      2: return (q2.size() != 0) ? q2[0] : 10'h0;
      default: return (q3.size() != 0) ? q3[0] : 10'h0;
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  // driver tasks
  task automatic load(input int i, input logic [9:0] w);
    case (i)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
    empty_r[i] = 1'b0;
  endtask

  task automatic do_pop(input int i);
    if (qsize(i) != 0) begin
      case (i)
        0: rd0 = q0.pop_front();
        1: rd1 = q1.pop_front();
        2: rd2 = q2.pop_front();
        default: rd3 = q3.pop_front();
      endcase
    end
    empty_r[i] = (qsize(i) == 0);
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (v) begin
      exp_q.delete();
      pipe     = 2'b00;
      m_rr     = 2'd0;
      exp_idle = 1'b1;
      m_data   = 10'h0;
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then apply FIFO pops after the rising edge.
  task automatic step();
    logic [3:0] emp, exp_pop, pop_seen, exp_push;
    logic       gv;
    logic [1:0] gi, c;
    logic [9:0] w;
    @(negedge clk);
    emp = empty_r;
    gv  = 1'b0;
    gi  = 2'd0;
    if (!reset && active && !(|almost_full)) begin
      for (int k = 0; k < 4; k++) begin
        c = m_rr + 2'(k);
        if (!gv && !emp[c]) begin
          gv = 1'b1;
          gi = c;
        end
      end
    end
    exp_pop = gv ? (4'b0001 << gi) : 4'b0000;
    check_eq("pop", {12'h0, pop_in}, {12'h0, exp_pop});
    exp_push = 4'b0000;
    if (pipe[0]) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 16'd1, 16'd0);
      end else begin
        w        = exp_q.pop_front();
        m_data   = w;
        exp_push = 4'b0001 << w[9:8];
      end
    end
    check_eq("push", {12'h0, push_out}, {12'h0, exp_push});
    check_eq("data", {6'h0, data_out}, {6'h0, m_data});
    check_eq("idle", {15'h0, idle}, {15'h0, exp_idle});
    pop_seen = pop_in;
    for (int i = 0; i < 4; i++) begin
      if (pop_seen[i]) exp_q.push_back(front(i));
    end
    exp_idle = reset ? 1'b1 : ((&emp) & ~pipe[1] & ~(|exp_pop));
    if (gv) m_rr = gi + 2'd1;
    pipe[0] = pipe[1];
    pipe[1] = |pop_seen;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pop_seen[i]) do_pop(i);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    active      = 1'b0;
    almost_full = 4'b0000;
    empty_r     = 4'hf;
    rd0 = 10'h0; rd1 = 10'h0; rd2 = 10'h0; rd3 = 10'h0;
    set_reset(1'b1);

    // reset with a word pending, then released while inactive
    load(0, 10'h001);
    run(3);
    set_reset(1'b0);
    run(3);

    // single word: FIFO0 -> FIFO4
    active = 1'b1;
    run(6);

    // routing: one word per input, each to a different output
    load(0, 10'h001); load(1, 10'h101); load(2, 10'h201); load(3, 10'h301);
    run(8);
    load(3, 10'h001);
    run(5);

    // fairness from rr_ptr = 0, then wrap via FIFO3
    set_reset(1'b1);
    run(1);
    set_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      load(0, 10'h010 + 10'(i));
      load(2, 10'h320 + 10'(i));
    end
    run(9);
    load(3, 10'h133);
    load(0, 10'h234);
    run(6);

    // backpressure on a FIFO1 stream
    for (int i = 0; i < 8; i++) load(1, {2'(i), 8'h40 + 8'(i)});
    run(2);
    almost_full = 4'b0100;
    run(5);
    almost_full = 4'b0000;
    run(12);

    // active dropping mid-stream
    for (int i = 0; i < 6; i++) load(2, {2'(3 - (i % 4)), 8'h80 + 8'(i)});
    run(2);
    active = 1'b0;
    run(4);
    active = 1'b1;
    run(10);

    // reset mid-stream
    for (int i = 0; i < 6; i++) load(0, {2'(i % 4), 8'hc0 + 8'(i)});
    load(3, 10'h2ee);
    run(2);
    set_reset(1'b1);
    run(2);
    set_reset(1'b0);
    run(14);

    // random traffic with backpressure and active toggles
    for (int cyc = 0; cyc < 300; cyc++) begin
      if ($urandom_range(0, 2) != 0) begin
        int f;
        f = $urandom_range(0, 3);
        if (qsize(f) < 5) load(f, 10'($urandom_range(0, 1023)));
      end
      if ($urandom_range(0, 9) == 0) almost_full = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) almost_full = 4'b0000;
      active = ($urandom_range(0, 7) != 0);
      step();
    end
    almost_full = 4'b0000;
    active      = 1'b1;
    run(30);
    check_eq("drained_inputs", 16'(q0.size() + q1.size() + q2.size() + q3.size()), 16'd0);
    check_eq("drained_sb", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
